// File: rtl/i2c_write_master_p.sv
// Write-only I2C master: START, 7-bit address + W, up to MAX_BYTES data bytes, STOP.
// Optional slave clock stretching is compiled in with `define I2C_CLKSTRETCH_EN.
module i2c_write_master_p #(
  parameter  int CLK_DIV   = 4,
  parameter  int MAX_BYTES = 4,
  localparam int LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [6:0]             addr,
  input  logic [LEN_W-1:0]       len,
  input  logic [8*MAX_BYTES-1:0] data,
  input  logic                   sda_i,
  input  logic                   scl_i,
  output logic                   sda_oe,
  output logic                   scl_oe,
  output logic                   busy,
  output logic                   done,
  output logic                   nack
);

  typedef enum logic [2:0] {IDLE, START, ADDR, ACK_A, DATA, ACK_D, STOP} state_t;

  state_t                 state, state_nxt;
  logic [9:0]             qcnt;
  logic [1:0]             quarter;
  logic [2:0]             bit_cnt;
  logic [LEN_W-1:0]       byte_cnt;
  logic [LEN_W-1:0]       len_r;
  logic [6:0]             addr_r;
  logic [8*MAX_BYTES-1:0] data_r;
  logic [7:0]             shreg;
  logic                   ack_r;
  logic                   hold;
  logic                   q_last;
  logic                   slot_end;
  logic                   accept;

`ifdef I2C_CLKSTRETCH_EN
  // A slave holding SCL low while we have released it freezes the high half of the slot.
  assign hold = (state != IDLE) && quarter[1] && !scl_oe && !scl_i;
`else
  logic unused_scl_i;
  assign unused_scl_i = scl_i;
  assign hold         = 1'b0;
`endif

  assign q_last   = (qcnt == 10'(CLK_DIV - 1)) && !hold;
  assign slot_end = q_last && (quarter == 2'd3);
  // The done cycle is already IDLE, so it must be excluded explicitly.
  assign accept   = (state == IDLE) && start && !done;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = START;
      START: if (slot_end) state_nxt = ADDR;
      ADDR:  if (slot_end && bit_cnt == 3'd7) state_nxt = ACK_A;
      ACK_A: if (slot_end) state_nxt = (ack_r || len_r == '0) ? STOP : DATA;
      DATA:  if (slot_end && bit_cnt == 3'd7) state_nxt = ACK_D;
      ACK_D: if (slot_end)
               state_nxt = (ack_r || byte_cnt == len_r - LEN_W'(1)) ? STOP : DATA;
      STOP:  if (slot_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sda_oe = 1'b0;
    scl_oe = 1'b0;
    case (state)
      START: sda_oe = quarter[1];
      ADDR, DATA: begin
        scl_oe = ~quarter[1];
        sda_oe = ~shreg[7];
      end
      ACK_A, ACK_D: scl_oe = ~quarter[1];
      STOP: begin
        sda_oe = ~quarter[1];
        scl_oe = (quarter == 2'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      qcnt     <= '0;
      quarter  <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      nack     <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (state == IDLE) begin
        qcnt     <= '0;
        quarter  <= '0;
        bit_cnt  <= '0;
        byte_cnt <= '0;
        if (accept) begin
          busy <= 1'b1;
          nack <= 1'b0;
        end
      end else begin
        if (q_last) begin
          qcnt    <= '0;
          quarter <= quarter + 2'd1;
        end else if (!hold) begin
          qcnt <= qcnt + 10'd1;
        end
        if (slot_end) begin
          case (state)
            ADDR, DATA: bit_cnt <= bit_cnt + 3'd1;
            ACK_A: begin
              if (ack_r) nack <= 1'b1;
              byte_cnt <= '0;
            end
            ACK_D: begin
              if (ack_r) nack <= 1'b1;
              else       byte_cnt <= byte_cnt + LEN_W'(1);
            end
            STOP: begin
              busy <= 1'b0;
              done <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Payload path: captured at accept, shifted out MSB-first, reloaded after each ACK slot.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_r <= addr;
      len_r  <= (len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : len;
      data_r <= data;
    end
    if (q_last && quarter == 2'd2) ack_r <= sda_i;
    if (slot_end) begin
      case (state)
        START:      shreg <= {addr_r, 1'b0};
        ADDR, DATA: shreg <= {shreg[6:0], 1'b0};
        ACK_A, ACK_D: begin
          shreg  <= data_r[8*MAX_BYTES-1 -: 8];
          data_r <= data_r << 8;
        end
        default: ;
      endcase
    end
  end

endmodule
